// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs an opcode, register numbers and a 64-bit signed immediate into a
// 32-bit LEGv8 instruction word. It is the inverse of the decode-stage
// immediate extraction and is used by the self-test/boot loader to build
// instruction memory images. Each emitted word carries its byte write
// address and an error flag.
//
// The pipeline has two stages with valid/ready handshakes:
//   S1 registers the request.
//   S2 registers the encoded word, the error flag and the address.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready
//   in_fmt     0=R, 1=I, 2=D, 3=CB, 4=B; 5-7 are illegal
//   in_opcode  opcode, left-justified (the MSBs are used)
//   in_rd      Rd/Rt
//   in_rn      Rn
//   in_rm      Rm
//   in_imm     signed immediate (shamt for R)
//   out_valid  word valid
//   out_ready  consumer ready
//   out_instr  encoded word
//   out_addr   byte address of out_instr
//   out_err    immediate out of range, or illegal format
//   err_count  saturating count of emitted words with out_err=1
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter logic [63:0] ADDR_STEP = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [10:0] in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rn,
    input  logic [4:0]  in_rm,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_CB = 3'd3,
        FMT_B  = 3'd4
    } fmt_e;

    // An immediate fits an n-bit signed field when every bit from n-1 upwards
    // is a copy of the sign bit.
    function automatic logic fits_signed(input logic [63:0] v, input int n);
        logic [63:0] top;
        top = $unsigned($signed(v) >>> (n - 1));
        return (top == '0) || (top == '1);
    endfunction

    // S1 request register
    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [10:0] s1_opcode;
    logic [4:0]  s1_rd, s1_rn, s1_rm;
    logic [63:0] s1_imm;

    // S2 control and the address counter
    logic        s2_valid;
    logic        s2_load;
    logic [63:0] next_addr;

    // Combinational encoding of the S1 contents
    logic [31:0] enc_instr;
    logic        enc_err;

    // S2 takes a new word whenever it is empty or its word drains this cycle.
    // S1 can then take a new request, because its word moves into S2.
    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    // NOTE: every output of an always_comb block is given a default first, so
    // that no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        enc_instr = 32'h0;
        enc_err   = 1'b0;
        case (fmt_e'(s1_fmt))
            FMT_R: begin
                enc_instr = {s1_opcode, s1_rm, s1_imm[5:0], s1_rn, s1_rd};
                enc_err   = |s1_imm[63:6];
            end
            FMT_I: begin
                enc_instr = {s1_opcode[10:1], s1_imm[11:0], s1_rn, s1_rd};
                enc_err   = !fits_signed(s1_imm, 12);
            end
            FMT_D: begin
                enc_instr = {s1_opcode, s1_imm[8:0], 2'b00, s1_rn, s1_rd};
                enc_err   = !fits_signed(s1_imm, 9);
            end
            FMT_CB: begin
                enc_instr = {s1_opcode[10:3], s1_imm[18:0], s1_rd};
                enc_err   = !fits_signed(s1_imm, 19);
            end
            FMT_B: begin
                enc_instr = {s1_opcode[10:5], s1_imm[25:0]};
                enc_err   = !fits_signed(s1_imm, 26);
            end
            default: begin
                enc_instr = 32'h0;
                enc_err   = 1'b1;
            end
        endcase
    end

    // NOTE: the S1 payload is not reset. s1_valid qualifies it, so resetting
    // the payload would only add reset fan-out to plain datapath flops.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_fmt    <= in_fmt;
            s1_opcode <= in_opcode;
            s1_rd     <= in_rd;
            s1_rn     <= in_rn;
            s1_rm     <= in_rm;
            s1_imm    <= in_imm;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments. Every flop
    // then samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_instr <= 32'h0;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
            next_addr <= BASE_ADDR;
            err_count <= 16'h0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                // A drain with no new word leaves the payload unchanged.
                // Payload and address change only when a real word enters S2.
                if (s1_valid) begin
                    out_instr <= enc_instr;
                    out_err   <= enc_err;
                    out_addr  <= next_addr;
                    next_addr <= next_addr + ADDR_STEP;
                end
            end
            if (s2_valid && out_ready && out_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
